// File: rtl/toggle_hs_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_hs_pkg
// Description : Shared types and default sizes for the toggle handshake receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package toggle_hs_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } hs_state_e;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage : toggle_hs_pkg
`default_nettype wire

// File: rtl/toggle_hs_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_hs_receiver_if
// Description : Toggle request/ack side plus downstream valid/ready side.
// Revision    : 1.0 - initial release
// ============================================================================
interface toggle_hs_receiver_if #(
    parameter int DATA_W = 8
);
    logic              req_tgl;
    logic [DATA_W-1:0] data_in;
    logic              ack_tgl;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    // slave = the receiver block; master = transmitter plus downstream sink
    modport slave (
        input  req_tgl,
        input  data_in,
        input  dout_ready,
        output ack_tgl,
        output dout,
        output dout_valid
    );

    modport master (
        output req_tgl,
        output data_in,
        output dout_ready,
        input  ack_tgl,
        input  dout,
        input  dout_valid
    );
endinterface : toggle_hs_receiver_if
`default_nettype wire

// File: rtl/toggle_hs_receiver_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Single-bit multi-flop synchroniser, resets to 0 (async, active-low).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/toggle_hs_receiver.sv
`default_nettype none
// ============================================================================
// Module      : toggle_hs_receiver
// Description : Two-phase request receiver presenting words on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_hs_receiver
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    toggle_hs_receiver_if.slave hs,
    output logic              err_overrun,
    input  wire logic         err_clr,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_VALID = VALID;

    logic [0:0]        r_state;
    logic              r_ack;
    logic [DATA_W-1:0] r_dout;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    logic w_req_s;
    logic w_pending;
    logic w_accept;
    logic w_overrun;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (hs.req_tgl),
        .o_q (w_req_s)
    );

    assign w_pending = (w_req_s != r_ack);
    assign w_accept  = (r_state == ST_VALID) && hs.dout_ready;
    // In VALID the request must still differ from ack; equality means a second toggle
    assign w_overrun = (r_state == ST_VALID) && !w_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_dout  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        r_dout  <= hs.data_in;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_accept) begin
                        r_ack   <= ~r_ack;
                        r_count <= r_count + CNT_W'(1);
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_overrun) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign hs.ack_tgl    = r_ack;
    assign hs.dout       = r_dout;
    assign hs.dout_valid = (r_state == ST_VALID);
    assign err_overrun   = r_err;
    assign xfer_count    = r_count;

endmodule : toggle_hs_receiver
`default_nettype wire

// File: doc/toggle_hs_receiver.md
Name: toggle_hs_receiver

Overview:
Receiving end of a two-phase (toggle) request/acknowledge handshake. The transmitter flips req_tgl once per word, a T-flip-flop style toggle, and holds data_in stable until ack_tgl flips. This block synchronises req_tgl into clk, captures the bundled data, and presents it downstream on a valid/ready interface. It returns the acknowledge as a toggle on ack_tgl once the word is accepted. Sits at a clock-domain or module boundary wherever a toggle-encoded request arrives.

Parameters:
DATA_W, 8, width of data_in/dout
SYNC_STAGES, 2, number of flops in the req_tgl synchroniser (minimum 2)
CNT_W, 16, width of transfer counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-low
req_tgl  in  1  request toggle from transmitter; each level change = one new word
data_in  in  DATA_W  bundled data; stable from req toggle until ack toggle
ack_tgl  out  1  acknowledge toggle back to transmitter
dout  out  DATA_W  captured word
dout_valid  out  1  dout holds an unaccepted word
dout_ready  in  1  downstream accepts dout when high with dout_valid
err_overrun  out  1  sticky protocol-violation flag
err_clr  in  1  synchronous clear of err_overrun
xfer_count  out  CNT_W  number of accepted words, wraps

Behaviour:
- Reset (rst=0, async): sync chain all 0, req_s=0, ack_tgl=0, dout=0, dout_valid=0, err_overrun=0, xfer_count=0, state=IDLE.
- req_s = output of last synchroniser flop. data_in is NOT synchronised; it is sampled directly, which is legal by the bundled-data rule.
- Pending request is defined as req_s != ack_tgl.
- IDLE:
  - dout_valid=0.
  - If pending: at the next edge, dout<=data_in, dout_valid<=1, go to VALID.
- VALID:
  - dout_valid=1; dout is held constant.
  - If dout_ready=1: at that edge, dout_valid<=0, ack_tgl<=~ack_tgl, xfer_count<=xfer_count+1 (mod 2^CNT_W), go to IDLE.
  - If req_s==ack_tgl, meaning req toggled again before ack: err_overrun<=1. Remain in VALID, dout unchanged, no extra capture.
- Latency:
  - Edge E0 = first edge sampling the new req_tgl level.
  - dout_valid is high after edge E0+SYNC_STAGES.
  - With dout_ready tied high, ack_tgl toggles one edge later.
- Throughput: at least one IDLE cycle between words. A new capture never occurs on the same edge as ack_tgl toggles.
- err_clr=1: err_overrun<=0 on the next edge. If a violation and err_clr occur in the same cycle, set wins.
- Reset mid-operation: everything returns to reset values and the in-flight word is dropped. If req_tgl=1 after reset, it appears as a pending request once synchronised; the transmitter must be reset together with this block.
- dout_ready while dout_valid=0 is ignored.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Package toggle_hs_pkg: state enum {IDLE, VALID}, default DATA_W/SYNC_STAGES/CNT_W constants.
- Sub-module sync_chain (params STAGES, reset value 0, async active-low reset) for req_tgl. Reusable for any single-bit CDC.
- Everything else stays in the top module.

Test Plan:
1. Reset, then req_tgl 0->1 with data_in=8'hA5 and dout_ready=1 -> dout_valid high after edge E0+2 with dout=8'hA5. One edge later ack_tgl=1, xfer_count=1, dout_valid=0.
2. Back-pressure: dout_ready=0, toggle req with data_in=8'h3C -> dout_valid stays high and dout=8'h3C for 10 cycles, ack_tgl unchanged. Raise dout_ready -> ack toggles next edge, xfer_count increments.
3. Stream of 4 words (11,22,33,44), bench transmitter waits for each ack toggle -> four captures in order, ack_tgl ends at 0, xfer_count=4, err_overrun=0.
4. Overrun: dout_ready=0, toggle req twice (data 8'h55 then change) -> err_overrun=1, dout stays 8'h55, no second valid. Pulse err_clr -> err_overrun=0 next edge.
5. Reset mid-transfer: assert rst while dout_valid=1 -> all outputs 0 immediately (async). Release with req_tgl=1 -> new capture after SYNC_STAGES+1 edges.
6. Wrap: CNT_W=2, run 5 transfers -> xfer_count sequence 1,2,3,0,1.
